// File: rtl/dcache_stage_sb_pkg.sv
// Shared types and helpers for the dcache_stage_sb memory stage and its store buffer.
// The store-buffer entry is sized by DCS_ADDR_W/DCS_DATA_W. The top-level
// ADDR_WIDTH/DATA_WIDTH parameters must keep these same values.
package dcache_stage_sb_pkg;

   localparam int unsigned DCS_ADDR_W = 32;
   localparam int unsigned DCS_DATA_W = 32;

   typedef struct packed {
      logic [DCS_ADDR_W-1:0] addr;
      logic [DCS_DATA_W-1:0] data;
      logic                  is_byte;
   } sb_entry_t;

   typedef enum logic [1:0] {
      DCS_IDLE    = 2'd0,
      DCS_LD_BUSY = 2'd1,
      DCS_ST_BUSY = 2'd2
   } dcs_state_e;

   // Little-endian byte lane select, zero-extended to the data width.
   function automatic logic [DCS_DATA_W-1:0] byte_lane(input logic [DCS_DATA_W-1:0] word,
                                                       input logic [1:0]            lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'h00;
      endcase
      return {{(DCS_DATA_W-8){1'b0}}, b};
   endfunction

endpackage

// File: rtl/dcache_stage_sb_sb_fifo.sv
// Store buffer FIFO: entry storage, wrapping pointers, occupancy count,
// full/empty flags and a youngest-match word-address search over valid entries.
module dcache_stage_sb_sb_fifo
   import dcache_stage_sb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  sb_entry_t               push_entry,
   input  logic                    pop,
   output sb_entry_t               head_entry,
   output logic                    full,
   output logic                    empty,
   input  logic [DCS_ADDR_W-3:0]   lookup_word,
   output logic                    hit,
   output sb_entry_t               hit_entry
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   sb_entry_t     mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full       = (count_r == CW'(DEPTH));
   assign empty      = (count_r == '0);
   assign do_pop_s   = pop & ~empty;
   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign do_push_s  = push & (~full | do_pop_s);
   assign head_entry = mem_r[rd_ptr_r];

   // Entry storage: written at the tail on push.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_entry;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      logic [PW-1:0] idx_v;
      logic          match_v;
      hit       = 1'b0;
      hit_entry = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         idx_v   = rd_ptr_r + PW'(i);
         match_v = (i < int'(count_r)) &&
                   (mem_r[idx_v].addr[DCS_ADDR_W-1:2] == lookup_word);
         if (match_v) begin
            hit       = 1'b1;
            hit_entry = mem_r[idx_v];
         end else begin
            hit       = hit;
            hit_entry = hit_entry;
         end
      end
   end

endmodule

// File: rtl/dcache_stage_sb.sv
// Memory stage between ALU and WB with a FIFO store buffer in front of the data cache.
// Stores retire to WB immediately and drain in the background. Loads check the
// buffer first. R-type results pass through in one cycle.
// Optional feature macro: DCACHE_SB_FWD_EN enables load forwarding from the
// youngest matching buffered store. Without it, any match holds the load
// until that store drains.
module dcache_stage_sb
   import dcache_stage_sb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SB_DEPTH   = 4,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned PC_WIDTH   = 32
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall_pipeline,
   output logic                  stage_ready,
   input  logic                  req_valid,
   input  logic                  mem_instr,
   input  logic                  int_instr,
   input  logic                  req_is_store,
   input  logic                  req_is_byte,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic [REG_AW-1:0]     req_dst_reg,
   input  logic [PC_WIDTH-1:0]   req_pc,
   output logic                  dc_req_valid,
   output logic                  dc_req_is_store,
   output logic                  dc_req_is_byte,
   output logic [ADDR_WIDTH-1:0] dc_req_addr,
   output logic [DATA_WIDTH-1:0] dc_req_data,
   input  logic                  dc_ready,
   input  logic                  dc_rsp_valid,
   input  logic [DATA_WIDTH-1:0] dc_rsp_data,
   output logic                  write_rf,
   output logic [REG_AW-1:0]     dest_rf,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [PC_WIDTH-1:0]   wb_instr_pc,
   output logic                  data_bp_valid,
   output logic [DATA_WIDTH-1:0] data_bypass,
   output logic                  xcpt_addr_fault,
   output logic [ADDR_WIDTH-1:0] xcpt_addr_val
);

`ifdef DCACHE_SB_FWD_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif

   dcs_state_e state_r, state_next_s;

   sb_entry_t push_entry_s, head_entry_s, hit_entry_s;
   logic      sb_full_s, sb_empty_s, sb_hit_s, sb_push_s, sb_pop_s;

   logic misalign_s, is_store_s, is_load_s, accept_s;
   logic fwd_ok_s, ld_blocked_s, load_fwd_s, load_miss_s, drain_pri_s;
   logic load_issue_s, drain_start_s, ld_done_s;
   logic [DATA_WIDTH-1:0] fwd_data_s;

   // Context of the load waiting on the cache.
   logic [REG_AW-1:0]   ld_dst_r;
   logic [PC_WIDTH-1:0] ld_pc_r;
   logic [1:0]          ld_lane_r;
   logic                ld_byte_r;

   logic                  dc_valid_next_s, dc_store_next_s, dc_byte_next_s;
   logic [ADDR_WIDTH-1:0] dc_addr_next_s;
   logic [DATA_WIDTH-1:0] dc_data_next_s;
   logic                  write_rf_next_s, fault_next_s;
   logic [REG_AW-1:0]     dest_next_s;
   logic [DATA_WIDTH-1:0] rsp_data_next_s;
   logic [PC_WIDTH-1:0]   pc_next_s;
   logic [ADDR_WIDTH-1:0] fault_addr_next_s;

   assign push_entry_s.addr    = req_addr;
   assign push_entry_s.data    = req_data;
   assign push_entry_s.is_byte = req_is_byte;

   dcache_stage_sb_sb_fifo #(.DEPTH(SB_DEPTH)) u_sb_fifo (
      .clock       (clock),
      .reset       (reset),
      .push        (sb_push_s),
      .push_entry  (push_entry_s),
      .pop         (sb_pop_s),
      .head_entry  (head_entry_s),
      .full        (sb_full_s),
      .empty       (sb_empty_s),
      .lookup_word (req_addr[ADDR_WIDTH-1:2]),
      .hit         (sb_hit_s),
      .hit_entry   (hit_entry_s)
   );

   // Request classification. A misaligned word access is never executed.
   assign misalign_s = mem_instr & ~req_is_byte & (req_addr[1:0] != 2'b00);
   assign is_store_s = mem_instr &  req_is_store & ~misalign_s;
   assign is_load_s  = mem_instr & ~req_is_store & ~misalign_s;

   // Forwarding rule: a word store always forwards. A byte store forwards only
   // to a byte load at the same byte address.
   assign fwd_ok_s     = FWD_EN & (~hit_entry_s.is_byte |
                                   (req_is_byte & (hit_entry_s.addr == req_addr)));
   assign ld_blocked_s = sb_hit_s & ~fwd_ok_s;
   assign load_fwd_s   = is_load_s & sb_hit_s & fwd_ok_s;
   assign load_miss_s  = is_load_s & ~sb_hit_s;
   // A full buffer wins the cache over a new load. That load waits one turn.
   assign drain_pri_s  = sb_full_s & dc_ready;

   assign stage_ready = (state_r == DCS_IDLE) &
                        ~(is_store_s & sb_full_s) &
                        ~(is_load_s & ld_blocked_s) &
                        ~(load_miss_s & drain_pri_s);

   assign accept_s      = req_valid & stage_ready & ~stall_pipeline;
   assign load_issue_s  = accept_s & load_miss_s;
   assign drain_start_s = (state_r == DCS_IDLE) & ~load_issue_s & ~sb_empty_s & dc_ready;
   assign ld_done_s     = (state_r == DCS_LD_BUSY) & dc_rsp_valid;
   assign sb_push_s     = accept_s & is_store_s;
   assign sb_pop_s      = (state_r == DCS_ST_BUSY) & dc_rsp_valid;

   assign fwd_data_s = ~req_is_byte         ? hit_entry_s.data :
                       hit_entry_s.is_byte ? byte_lane(hit_entry_s.data, 2'b00) :
                                             byte_lane(hit_entry_s.data, req_addr[1:0]);

   assign data_bp_valid = write_rf_next_s;
   assign data_bypass   = rsp_data_next_s;

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_r <= DCS_IDLE;
      else        state_r <= state_next_s;
   end

   // FSM next state: a load issue takes the cache before a background drain.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         DCS_IDLE: begin
            if (load_issue_s)       state_next_s = DCS_LD_BUSY;
            else if (drain_start_s) state_next_s = DCS_ST_BUSY;
            else                    state_next_s = DCS_IDLE;
         end
         DCS_LD_BUSY: begin
            if (dc_rsp_valid) state_next_s = DCS_IDLE;
            else              state_next_s = DCS_LD_BUSY;
         end
         DCS_ST_BUSY: begin
            if (dc_rsp_valid) state_next_s = DCS_IDLE;
            else              state_next_s = DCS_ST_BUSY;
         end
         default: state_next_s = DCS_IDLE;
      endcase
   end

   // Cache request: launched from IDLE, then held stable until dc_ready takes it.
   always_comb begin
      dc_valid_next_s = dc_req_valid;
      dc_store_next_s = dc_req_is_store;
      dc_byte_next_s  = dc_req_is_byte;
      dc_addr_next_s  = dc_req_addr;
      dc_data_next_s  = dc_req_data;
      if (load_issue_s) begin
         dc_valid_next_s = 1'b1;
         dc_store_next_s = 1'b0;
         dc_byte_next_s  = req_is_byte;
         dc_addr_next_s  = req_addr;
         dc_data_next_s  = '0;
      end else if (drain_start_s) begin
         dc_valid_next_s = 1'b1;
         dc_store_next_s = 1'b1;
         dc_byte_next_s  = head_entry_s.is_byte;
         dc_addr_next_s  = head_entry_s.addr;
         dc_data_next_s  = head_entry_s.data;
      end else if (dc_req_valid & dc_ready) begin
         dc_valid_next_s = 1'b0;
      end else begin
         dc_valid_next_s = dc_req_valid;
      end
   end

   // WB results: cache load completion, R-type, forwarded load, store retire, or fault.
   always_comb begin
      write_rf_next_s   = 1'b0;
      fault_next_s      = 1'b0;
      dest_next_s       = dest_rf;
      rsp_data_next_s   = rsp_data;
      pc_next_s         = wb_instr_pc;
      fault_addr_next_s = xcpt_addr_val;
      if (ld_done_s) begin
         write_rf_next_s = 1'b1;
         dest_next_s     = ld_dst_r;
         rsp_data_next_s = ld_byte_r ? byte_lane(dc_rsp_data, ld_lane_r) : dc_rsp_data;
         pc_next_s       = ld_pc_r;
      end else if (accept_s) begin
         if (misalign_s) begin
            fault_next_s      = 1'b1;
            fault_addr_next_s = req_addr;
            pc_next_s         = req_pc;
         end else if (is_store_s) begin
            pc_next_s = req_pc;
         end else if (load_fwd_s) begin
            write_rf_next_s = 1'b1;
            dest_next_s     = req_dst_reg;
            rsp_data_next_s = fwd_data_s;
            pc_next_s       = req_pc;
         end else if (~mem_instr & int_instr) begin
            write_rf_next_s = 1'b1;
            dest_next_s     = req_dst_reg;
            rsp_data_next_s = req_data;
            pc_next_s       = req_pc;
         end else begin
            pc_next_s = wb_instr_pc;
         end
      end else begin
         pc_next_s = wb_instr_pc;
      end
   end

   // Registered cache request outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dc_req_valid    <= 1'b0;
         dc_req_is_store <= 1'b0;
         dc_req_is_byte  <= 1'b0;
         dc_req_addr     <= '0;
         dc_req_data     <= '0;
      end else begin
         dc_req_valid    <= dc_valid_next_s;
         dc_req_is_store <= dc_store_next_s;
         dc_req_is_byte  <= dc_byte_next_s;
         dc_req_addr     <= dc_addr_next_s;
         dc_req_data     <= dc_data_next_s;
      end
   end

   // Capture the issuing load's destination, PC and byte lane for its completion.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ld_dst_r  <= '0;
         ld_pc_r   <= '0;
         ld_lane_r <= 2'b00;
         ld_byte_r <= 1'b0;
      end else if (load_issue_s) begin
         ld_dst_r  <= req_dst_reg;
         ld_pc_r   <= req_pc;
         ld_lane_r <= req_addr[1:0];
         ld_byte_r <= req_is_byte;
      end
   end

   // Registered WB and exception outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         write_rf        <= 1'b0;
         dest_rf         <= '0;
         rsp_data        <= '0;
         wb_instr_pc     <= '0;
         xcpt_addr_fault <= 1'b0;
         xcpt_addr_val   <= '0;
      end else begin
         write_rf        <= write_rf_next_s;
         dest_rf         <= dest_next_s;
         rsp_data        <= rsp_data_next_s;
         wb_instr_pc     <= pc_next_s;
         xcpt_addr_fault <= fault_next_s;
         xcpt_addr_val   <= fault_addr_next_s;
      end
   end

endmodule
